// File: rtl/score_bcd_converter.sv
// score_bcd_converter: 32-bit binary to DIGITS-digit BCD, one double-dabble iteration per cycle (33-cycle latency).
// Define BCD_LEADING_BLANK_EN to replace leading zero digits with 4'hF in bcd_out.
module score_bcd_converter #(
  parameter int DIGITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [31:0]         bin_in,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                overflow
);
  function automatic logic [31:0] max_val(input int n);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 0; i < n; i++) r = r * 32'd10;
    return r - 32'd1;
  endfunction
  localparam logic [31:0] MAX = max_val(DIGITS);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] op_q, op_d;
  logic [4*DIGITS-1:0] scr_q, scr_d, adj, fmt, bcd_q, bcd_d;
  logic [5:0] cnt_q, cnt_d;
  logic pend_q, pend_d, busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
`ifdef BCD_LEADING_BLANK_EN
  logic nz;
`endif
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    scr_d = scr_q;
    cnt_d = cnt_q;
    pend_d = pend_q;
    busy_d = busy_q;
    done_d = 1'b0;
    bcd_d = bcd_q;
    ovf_d = ovf_q;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i+:4] = scr_q[4*i+:4] >= 4'd5 ? scr_q[4*i+:4] + 4'd3 : scr_q[4*i+:4];
    fmt = scr_q;
`ifdef BCD_LEADING_BLANK_EN
    nz = 1'b0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      nz = nz | (scr_q[4*i+:4] != 4'd0);
      fmt[4*i+:4] = nz ? scr_q[4*i+:4] : 4'hF;
    end
`endif
    case (state_q)
      IDLE: if (start) begin
        state_d = SHIFT;
        op_d = bin_in > MAX ? MAX : bin_in;
        pend_d = bin_in > MAX;
        scr_d = '0;
        cnt_d = '0;
        busy_d = 1'b1;
      end
      SHIFT: begin
        scr_d = {adj[4*DIGITS-2:0], op_q[31]};
        op_d = {op_q[30:0], 1'b0};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = DONE;
      end
      DONE: begin
        bcd_d = fmt;
        ovf_d = pend_q;
        done_d = 1'b1;
        busy_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q <= '0;
      scr_q <= '0;
      cnt_q <= '0;
      pend_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      bcd_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      scr_q <= scr_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      busy_q <= busy_d;
      done_q <= done_d;
      bcd_q <= bcd_d;
      ovf_q <= ovf_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign bcd_out = bcd_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_score_bcd_converter.sv
// tb_score_bcd_converter: randomized bench for score_bcd_converter (DIGITS=8) against an arithmetic decimal model.
module tb_score_bcd_converter;
  logic clk, rst, start, busy, done, overflow;
  logic [31:0] bin_in, bcd_out;
  int n_vec = 0, n_bad = 0;
  logic [31:0] vals [0:101];
  score_bcd_converter #(.DIGITS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic void model(input logic [31:0] v, output logic [31:0] b, output logic o);
    longint x;
    o = v > 32'd99999999;
    x = o ? 64'd99999999 : {32'd0, v};
    for (int i = 0; i < 8; i++) begin
      b[4*i+:4] = 4'(x % 10);
      x = x / 10;
    end
`ifdef BCD_LEADING_BLANK_EN
    for (int i = 7; i > 0 && b[4*i+:4] == 4'd0; i--) b[4*i+:4] = 4'hF;
`endif
  endfunction
  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return $urandom_range(0, 999);
      default: return $urandom_range(0, 99999999);
    endcase
  endfunction
  task automatic run(input logic [31:0] v);
    int lat;
    logic [31:0] eb, prev;
    logic eo, held;
    model(v, eb, eo);
    @(negedge clk);
    start = 1'b1;
    bin_in = v;
    @(posedge clk);
    #1 start = 1'b0;
    bin_in = $urandom;
    prev = bcd_out;
    held = 1'b1;
    chk("busy_after_accept", busy, 1);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 lat++;
      start = 1'b0;
      if (!done && bcd_out !== prev) held = 1'b0;
    end
    chk("latency", lat, 33);
    chk("hold_during_conv", held, 1);
    chk("busy_at_done", busy, 0);
    chk("bcd", bcd_out, eb);
    chk("ovf", overflow, eo);
    @(posedge clk);
    #1 chk("done_pulse", done, 0);
  endtask
  initial begin
    logic [31:0] eb;
    logic eo;
    int nd;
    rst = 1'b1;
    start = 1'b0;
    bin_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bcd", bcd_out, 0);
    chk("rst_ovf", overflow, 0);
    @(negedge clk) rst = 1'b0;
    run(32'd0);
    run(32'd12345678);
    run(32'd99999999);
    run(32'hFFFFFFFF);
    run(32'd7);
    run(32'd10000000);
    run(32'd100000000);
    run(32'd42);
    for (int i = 0; i < 20; i++) run(rnd());
    for (int e = 0; e < 102; e++) begin
      @(negedge clk);
      start = 1'b1;
      vals[e] = rnd();
      bin_in = vals[e];
      @(posedge clk);
      #1 chk("b2b_done", done, (e % 34) == 33);
      if (e % 34 == 33) begin
        model(vals[e-33], eb, eo);
        chk("b2b_bcd", bcd_out, eb);
        chk("b2b_ovf", overflow, eo);
      end
    end
    @(negedge clk);
    start = 1'b0;
    run(32'd123);
    @(negedge clk);
    start = 1'b1;
    bin_in = $urandom_range(1, 99999999);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_bcd", bcd_out, 0);
    chk("abort_ovf", overflow, 0);
    @(negedge clk) rst = 1'b0;
    nd = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (done) nd++;
    end
    chk("abort_no_done", nd, 0);
    run(32'd500);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
